// File: rtl/whack_pkg.sv
// Shared types and constants for the LED reaction-game round controller.
package whack_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_ARM,
    S_SHOW,
    S_HIT,
    S_MISS,
    S_OVER
  } state_t;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

  // Hits per timeout step when the speed-up option is built.
  localparam int HIT_INTERVAL = 5;

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit saturating BCD incrementer (9999 holds) with synchronous clear.
module bcd_counter4
  import whack_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        inc,
  output logic [15:0] value
);

  logic [15:0] value_next;
  logic        carry;

  // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    value_next = value;
    carry      = inc && (value != {4{BCD_MAX_DIGIT}});
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (value[i*4 +: 4] == BCD_MAX_DIGIT) begin
          value_next[i*4 +: 4] = 4'd0;
        end else begin
          value_next[i*4 +: 4] = value[i*4 +: 4] + 4'd1;
          carry                = 1'b0;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else begin
      value <= value_next;
    end
  end

endmodule

// File: rtl/whack_round_ctrl.sv
// Round controller for the LED reaction game: owns timer, target, scoring.
// Optional macro WHACK_SPEEDUP_EN shortens the SHOW timeout every few hits.
module whack_round_ctrl
  import whack_pkg::*;
#(
  parameter int NUM_LEDS      = 18,
  parameter int TIMER_W       = 11,
  parameter int GAP_TICKS     = 100,
  parameter int TIMEOUT_TICKS = 500,
  parameter int MAX_MISSES    = 3,
  parameter int TIMEOUT_STEP  = 50,
  parameter int TIMEOUT_MIN   = 150
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [NUM_LEDS-1:0] switches,
  input  logic [TIMER_W-1:0]  random_value,
  input  logic [TIMER_W-1:0]  timer_value,
  output logic                timer_enable,
  output logic                timer_reset,
  output logic [NUM_LEDS-1:0] leds,
  output logic [15:0]         score_bcd,
  output logic [3:0]          misses,
  output logic                game_over
);

  localparam int TGT_W = $clog2(NUM_LEDS);

  state_t              state_q, state_d;
  logic [TGT_W-1:0]    target_q;
  logic [TIMER_W-1:0]  target_full;
  logic [NUM_LEDS-1:0] sw_q, sw_qq, sw_edge;
  logic [TIMER_W-1:0]  timeout_q;
  logic [3:0]          miss_next;
  logic                game_clear, hit_inc, miss_inc;

  // Two-stage capture: the decision sees a rise one cycle after it is sampled.
  assign sw_edge     = sw_q & ~sw_qq;
  assign target_full = random_value % TIMER_W'(NUM_LEDS);
  assign miss_next   = misses + 4'd1;
  assign game_clear  = start && (state_q == S_IDLE || state_q == S_OVER);
  assign hit_inc     = (state_q == S_HIT)  && !start;
  assign miss_inc    = (state_q == S_MISS) && !start;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      target_q <= '0;
      sw_q     <= '0;
      sw_qq    <= '0;
      misses   <= '0;
    end else begin
      state_q <= state_d;
      sw_q    <= switches;
      sw_qq   <= sw_q;
      if (state_q == S_ARM) target_q <= target_full[TGT_W-1:0];
      if (game_clear)       misses   <= '0;
      else if (miss_inc)    misses   <= miss_next;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_OVER: if (start) state_d = S_GAP;
      S_GAP: begin
        if (start)                                       state_d = S_IDLE;
        else if (timer_value >= TIMER_W'(GAP_TICKS))     state_d = S_ARM;
      end
      S_ARM:  state_d = start ? S_IDLE : S_SHOW;
      S_SHOW: begin
        if (start)                        state_d = S_IDLE;
        else if (sw_edge[target_q])       state_d = S_HIT;
        else if (|sw_edge)                state_d = S_MISS;
        else if (timer_value >= timeout_q) state_d = S_MISS;
      end
      S_HIT:  state_d = start ? S_IDLE : S_GAP;
      S_MISS: begin
        if (start)                            state_d = S_IDLE;
        else if (miss_next == 4'(MAX_MISSES)) state_d = S_OVER;
        else                                  state_d = S_GAP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    timer_reset  = 1'b0;
    timer_enable = 1'b0;
    leds         = '0;
    game_over    = 1'b0;
    case (state_q)
      S_GAP:  timer_enable = 1'b1;
      S_SHOW: begin
        timer_enable = 1'b1;
        leds         = {{(NUM_LEDS-1){1'b0}}, 1'b1} << target_q;
      end
      S_OVER: begin
        timer_reset = 1'b1;
        leds        = '1;
        game_over   = 1'b1;
      end
      default: timer_reset = 1'b1;
    endcase
  end

  bcd_counter4 u_score (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (game_clear),
    .inc     (hit_inc),
    .value   (score_bcd)
  );

`ifdef WHACK_SPEEDUP_EN
  logic [2:0] hit_mod_q;

  always_ff @(posedge clk) begin
    if (!reset_n || game_clear) begin
      timeout_q <= TIMER_W'(TIMEOUT_TICKS);
      hit_mod_q <= '0;
    end else if (hit_inc) begin
      if (hit_mod_q == 3'(HIT_INTERVAL - 1)) begin
        hit_mod_q <= '0;
        if (timeout_q >= TIMER_W'(TIMEOUT_MIN + TIMEOUT_STEP))
          timeout_q <= timeout_q - TIMER_W'(TIMEOUT_STEP);
        else
          timeout_q <= TIMER_W'(TIMEOUT_MIN);
      end else begin
        hit_mod_q <= hit_mod_q + 3'd1;
      end
    end
  end
`else
  assign timeout_q = TIMER_W'(TIMEOUT_TICKS);
`endif

endmodule
